video_path_selector: RTL and testbench
======================================

# video_path_selector

Debounces the two board switches that pick the active video-processing path and drives the 2-bit path address consumed by the video pipeline's path multiplexer. A new address is applied only at a frame boundary (rising edge of `vsync`), so a frame is never split between two processing paths. Sits between the board switch inputs and the pipeline's path-select input.

## Interface
- `DEBOUNCE_CYCLES`, default 65536, number of consecutive stable synchronized samples required before a switch value is accepted; legal range ≥ 2.
- `clk` input 1 pipeline pixel clock; all logic is in this domain.
- `rst_n` input 1 reset, synchronous, active-low.
- `sw` input 2 raw board switches, asynchronous, may bounce.
- `vsync` input 1 active-high vertical sync from the timing generator, synchronous to `clk`.
- `adres` output 2 active path address to the path multiplexer.
- `pending` output 1 high while a debounced value differs from `adres` and is waiting for a frame boundary.
- `mode_change` output 1 one-cycle pulse in the cycle after `adres` changes.

## Operation
- Synchronizer: 2 flip-flops on `sw`, giving `sw_s`.
- Debounce: registers `cand` (2 bits) and `cnt` (width `$clog2(DEBOUNCE_CYCLES)`), plus `stable` (2 bits).
  - If `sw_s != cand`: `cand <= sw_s`, `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= cand`; `cnt` holds (saturates).
  - Else: `cnt <= cnt + 1`.
- Frame edge: `vsync_d <= vsync`; `frame_edge = vsync & ~vsync_d`.
- FSM, registered, 2 states:
  - IDLE: if `stable != adres`, go to ARMED.
  - ARMED: if `stable == adres`, go to IDLE; nothing is applied. Else if `frame_edge`, set `adres <= stable` and `mode_change <= 1`, then go to IDLE.
- `pending` = (state == ARMED).
- ARMED always applies the latest `stable` value, so target changes while armed collapse into a single apply.
- `vsync` held high for many cycles produces exactly one `frame_edge`.

## Timing
- Reset values: `adres`=0, `pending`=0, `mode_change`=0, `cand`=0, `stable`=0, `cnt`=0, synchronizer flops=0, `vsync_d`=0, state=IDLE.
- Reset mid-operation clears everything above. `adres` returns to 0 whatever `sw` is. The current switch value is then re-debounced and applied at a later frame edge.
- Latency from `sw` to `stable`: the switch change is first sampled at edge e0. `stable` updates at edge e0+`DEBOUNCE_CYCLES`+2, provided `sw` holds through that edge.
- Latency from `stable` to `pending`: ARMED is entered one edge after `stable` changes.
- A `frame_edge` in the same cycle that `stable` changes (state still IDLE) is ignored; the apply waits for the next frame.
- `adres` updates on the clock edge that samples the first high `vsync` while ARMED. `mode_change` is high for exactly the following cycle.

## Configuration
- `FRAME_SYNC_EN` defined (production):
  - Applies wait for `frame_edge` as described above.
- `FRAME_SYNC_EN` undefined:
  - `vsync` is ignored.
  - ARMED applies unconditionally on its first cycle: `adres` updates one edge after ARMED is entered.
  - `mode_change` pulses as normal; `pending` is high for exactly one cycle per change.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `FRAME_SYNC_EN` defined unless noted.
- Reset with `sw`=11: hold `rst_n`=0 for 3 cycles, then release with no `vsync` -> during reset `adres`=00, `pending`=0, `mode_change`=0. After release, `stable`=11 at edge e0+6 and `pending`=1 one edge later; `adres` stays 00.
- Clean change: `sw` 00→10, `vsync` rises 20 cycles later -> `adres`=10 on the first edge that samples `vsync`=1; `mode_change` high for 1 cycle; `pending` drops to 0.
- Bounce: `sw` toggles 00↔01 every 3 cycles for 30 cycles, then returns to 00 -> `stable` never changes, `pending`=0 throughout, no `mode_change`.
- Cancel: while ARMED toward 01, `sw` returns to 00 and re-debounces -> `pending` falls; a later `vsync` leaves `adres`=00 with no pulse.
- Retarget and long vsync: ARMED toward 01, `sw` changes to 11 and debounces before `vsync`; `vsync` then held high for 50 cycles -> `adres`=11, exactly one `mode_change`.
- Macro off: `sw` 00→01, `vsync` tied 0 -> `adres`=01 two edges after `stable` changes; `pending` high for 1 cycle; `mode_change` high for 1 cycle.

Source files
------------

// File: rtl/video_path_selector.sv
// Debounced video path selector: applies a new 2-bit path address only at a frame boundary.
// Define FRAME_SYNC_EN to wait for the rising edge of vsync; otherwise a debounced change applies immediately.
module video_path_selector #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sw,
    input  logic       vsync,
    output logic [1:0] adres,
    output logic       pending,
    output logic       mode_change
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        ARMED
    } state_t;

    logic [1:0]       sw_meta;
    logic [1:0]       sw_s;
    logic [1:0]       cand;
    logic [1:0]       stable;
    logic [CNT_W-1:0] cnt;
    logic             apply_ok;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] adres_nxt;
    logic       mode_change_nxt;

    // Two-flop synchronizer for the asynchronous, bouncing board switches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_meta <= 2'b00;
            sw_s    <= 2'b00;
        end else begin
            sw_meta <= sw;
            sw_s    <= sw_meta;
        end
    end

    // A candidate value is accepted once it has been seen unchanged long enough.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand   <= 2'b00;
            cnt    <= '0;
            stable <= 2'b00;
        end else if (sw_s != cand) begin
            cand <= sw_s;
            cnt  <= '0;
        end else if (cnt == CNT_MAX) begin
            stable <= cand;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef FRAME_SYNC_EN
    logic vsync_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_d <= 1'b0;
        end else begin
            vsync_d <= vsync;
        end
    end

    // Only the rising edge counts, so a long vsync pulse allows a single apply.
    assign apply_ok = vsync & ~vsync_d;
`else
    logic unused_vsync;

    assign unused_vsync = vsync;
    assign apply_ok     = 1'b1;
`endif

    // ARMED always applies the latest stable value, so retargets collapse into one apply.
    always_comb begin
        state_nxt       = state;
        adres_nxt       = adres;
        mode_change_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (stable != adres) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (stable == adres) begin
                    state_nxt = IDLE;
                end else if (apply_ok) begin
                    adres_nxt       = stable;
                    mode_change_nxt = 1'b1;
                    state_nxt       = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            adres       <= 2'b00;
            mode_change <= 1'b0;
        end else begin
            state       <= state_nxt;
            adres       <= adres_nxt;
            mode_change <= mode_change_nxt;
        end
    end

    assign pending = (state == ARMED);

endmodule

// File: tb/tb_video_path_selector.sv
// Directed self-checking bench for video_path_selector with DEBOUNCE_CYCLES = 4.
// Expectations follow FRAME_SYNC_EN, so the bench suits either build of the design.
module tb_video_path_selector;

    logic       clk;
    logic       rst_n;
    logic [1:0] sw;
    logic       vsync;
    logic [1:0] adres;
    logic       pending;
    logic       mode_change;
    logic [3:0] obs;

    int n_checks;
    int n_fail;

    video_path_selector #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw         (sw),
        .vsync      (vsync),
        .adres      (adres),
        .pending    (pending),
        .mode_change(mode_change)
    );

    // obs packs {adres, pending, mode_change} so one compare covers all outputs.
    assign obs = {adres, pending, mode_change};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] sw_val);
        rst_n = 1'b0;
        sw    = sw_val;
        vsync = 1'b0;
        wait_edges(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        sw    = 2'b11;
        vsync = 1'b0;
        rst_n = 1'b0;
        wait_edges(1);
        n_checks++;
        if (obs !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_first: got %b expected %b", obs, 4'b0000); end
        wait_edges(2);
        n_checks++;
        if (obs !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_hold: got %b expected %b", obs, 4'b0000); end
        rst_n = 1'b1;
        wait_edges(7);
        n_checks++;
        if (obs !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_stable_edge: got %b expected %b", obs, 4'b0000); end
        wait_edges(1);
        n_checks++;
        if (obs !== 4'b0010) begin n_fail++; $display("[TB] FAIL reset_armed: got %b expected %b", obs, 4'b0010); end
        wait_edges(1);
`ifdef FRAME_SYNC_EN
        n_checks++;
        if (obs !== 4'b0010) begin n_fail++; $display("[TB] FAIL reset_no_vsync: got %b expected %b", obs, 4'b0010); end
        wait_edges(1);
        n_checks++;
        if (obs !== 4'b0010) begin n_fail++; $display("[TB] FAIL reset_still_wait: got %b expected %b", obs, 4'b0010); end
`else
        n_checks++;
        if (obs !== 4'b1101) begin n_fail++; $display("[TB] FAIL reset_apply: got %b expected %b", obs, 4'b1101); end
        wait_edges(1);
        n_checks++;
        if (obs !== 4'b1100) begin n_fail++; $display("[TB] FAIL reset_pulse_end: got %b expected %b", obs, 4'b1100); end
`endif
    endtask

    task automatic test_clean_change;
        do_reset(2'b00);
        wait_edges(8);
        n_checks++;
        if (obs !== 4'b0000) begin n_fail++; $display("[TB] FAIL clean_idle: got %b expected %b", obs, 4'b0000); end
        sw = 2'b10;
        wait_edges(8);
        n_checks++;
        if (obs !== 4'b0010) begin n_fail++; $display("[TB] FAIL clean_armed: got %b expected %b", obs, 4'b0010); end
`ifdef FRAME_SYNC_EN
        wait_edges(12);
        n_checks++;
        if (obs !== 4'b0010) begin n_fail++; $display("[TB] FAIL clean_waiting: got %b expected %b", obs, 4'b0010); end
        vsync = 1'b1;
`endif
        wait_edges(1);
        n_checks++;
        if (obs !== 4'b1001) begin n_fail++; $display("[TB] FAIL clean_apply: got %b expected %b", obs, 4'b1001); end
        wait_edges(1);
        n_checks++;
        if (obs !== 4'b1000) begin n_fail++; $display("[TB] FAIL clean_pulse_end: got %b expected %b", obs, 4'b1000); end
        vsync = 1'b0;
    endtask

    task automatic test_bounce;
        int bad;
        bad = 0;
        do_reset(2'b00);
        wait_edges(8);
        for (int i = 0; i < 30; i++) begin
            sw = (((i / 3) % 2) != 0) ? 2'b01 : 2'b00;
            if (i == 15) vsync = 1'b1;
            if (i == 18) vsync = 1'b0;
            wait_edges(1);
            if (pending !== 1'b0 || mode_change !== 1'b0) bad++;
        end
        sw = 2'b00;
        for (int i = 0; i < 10; i++) begin
            wait_edges(1);
            if (pending !== 1'b0 || mode_change !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("[TB] FAIL bounce_activity: got %0d cycles expected %0d", bad, 0); end
        n_checks++;
        if (obs !== 4'b0000) begin n_fail++; $display("[TB] FAIL bounce_final: got %b expected %b", obs, 4'b0000); end
    endtask

`ifdef FRAME_SYNC_EN
    task automatic test_cancel;
        do_reset(2'b00);
        wait_edges(8);
        sw = 2'b01;
        wait_edges(8);
        n_checks++;
        if (obs !== 4'b0010) begin n_fail++; $display("[TB] FAIL cancel_armed: got %b expected %b", obs, 4'b0010); end
        sw = 2'b00;
        wait_edges(7);
        n_checks++;
        if (obs !== 4'b0010) begin n_fail++; $display("[TB] FAIL cancel_still_armed: got %b expected %b", obs, 4'b0010); end
        wait_edges(1);
        n_checks++;
        if (obs !== 4'b0000) begin n_fail++; $display("[TB] FAIL cancel_dropped: got %b expected %b", obs, 4'b0000); end
        vsync = 1'b1;
        wait_edges(1);
        n_checks++;
        if (obs !== 4'b0000) begin n_fail++; $display("[TB] FAIL cancel_vsync: got %b expected %b", obs, 4'b0000); end
        wait_edges(1);
        n_checks++;
        if (obs !== 4'b0000) begin n_fail++; $display("[TB] FAIL cancel_after: got %b expected %b", obs, 4'b0000); end
        vsync = 1'b0;
    endtask

    task automatic test_retarget_long_vsync;
        int pulses;
        do_reset(2'b00);
        wait_edges(8);
        sw = 2'b01;
        wait_edges(8);
        n_checks++;
        if (obs !== 4'b0010) begin n_fail++; $display("[TB] FAIL retarget_armed: got %b expected %b", obs, 4'b0010); end
        sw = 2'b11;
        wait_edges(8);
        n_checks++;
        if (obs !== 4'b0010) begin n_fail++; $display("[TB] FAIL retarget_waiting: got %b expected %b", obs, 4'b0010); end
        vsync = 1'b1;
        wait_edges(1);
        n_checks++;
        if (obs !== 4'b1101) begin n_fail++; $display("[TB] FAIL retarget_apply: got %b expected %b", obs, 4'b1101); end
        pulses = (mode_change === 1'b1) ? 1 : 0;
        for (int i = 0; i < 49; i++) begin
            wait_edges(1);
            if (mode_change === 1'b1) pulses++;
        end
        vsync = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_edges(1);
            if (mode_change === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 1) begin n_fail++; $display("[TB] FAIL retarget_pulses: got %0d expected %0d", pulses, 1); end
        n_checks++;
        if (obs !== 4'b1100) begin n_fail++; $display("[TB] FAIL retarget_final: got %b expected %b", obs, 4'b1100); end
    endtask
`else
    task automatic test_macro_off;
        do_reset(2'b00);
        wait_edges(8);
        sw = 2'b01;
        wait_edges(7);
        n_checks++;
        if (obs !== 4'b0000) begin n_fail++; $display("[TB] FAIL off_stable_edge: got %b expected %b", obs, 4'b0000); end
        wait_edges(1);
        n_checks++;
        if (obs !== 4'b0010) begin n_fail++; $display("[TB] FAIL off_armed: got %b expected %b", obs, 4'b0010); end
        wait_edges(1);
        n_checks++;
        if (obs !== 4'b0101) begin n_fail++; $display("[TB] FAIL off_apply: got %b expected %b", obs, 4'b0101); end
        wait_edges(1);
        n_checks++;
        if (obs !== 4'b0100) begin n_fail++; $display("[TB] FAIL off_pulse_end: got %b expected %b", obs, 4'b0100); end
        vsync = 1'b1;
        wait_edges(3);
        n_checks++;
        if (obs !== 4'b0100) begin n_fail++; $display("[TB] FAIL off_vsync_ignored: got %b expected %b", obs, 4'b0100); end
        vsync = 1'b0;
    endtask
`endif

    task automatic test_reset_mid;
        do_reset(2'b00);
        wait_edges(8);
        sw = 2'b10;
        wait_edges(10);
        vsync = 1'b1;
        wait_edges(2);
        vsync = 1'b0;
        wait_edges(2);
        n_checks++;
        if (obs !== 4'b1000) begin n_fail++; $display("[TB] FAIL mid_applied: got %b expected %b", obs, 4'b1000); end
        rst_n = 1'b0;
        wait_edges(1);
        n_checks++;
        if (obs !== 4'b0000) begin n_fail++; $display("[TB] FAIL mid_reset: got %b expected %b", obs, 4'b0000); end
        rst_n = 1'b1;
        wait_edges(7);
        n_checks++;
        if (obs !== 4'b0000) begin n_fail++; $display("[TB] FAIL mid_redebounce: got %b expected %b", obs, 4'b0000); end
        wait_edges(1);
        n_checks++;
        if (obs !== 4'b0010) begin n_fail++; $display("[TB] FAIL mid_rearmed: got %b expected %b", obs, 4'b0010); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        sw       = 2'b00;
        vsync    = 1'b0;
        $display("[TB] video_path_selector directed test start");
        test_reset();
        test_clean_change();
        test_bounce();
`ifdef FRAME_SYNC_EN
        test_cancel();
        test_retarget_long_vsync();
`else
        test_macro_off();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
